// File: rtl/dpram_arbiter_if.sv
// Requester-side and RAM-side signal bundle for dpram_arbiter.
// The arbiter takes the slave view; requesters and the RAM together form the master view.
interface dpram_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned AW      = 6,
  parameter int unsigned DW      = 8
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    req_we;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ*DW-1:0] req_wdata;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [NUM_REQ*DW-1:0] rsp_data;

  logic          ram_valid_a, ram_valid_b;
  logic          ram_ready_a, ram_ready_b;
  logic          ram_we_a,    ram_we_b;
  logic [AW-1:0] ram_addr_a,  ram_addr_b;
  logic [DW-1:0] ram_data_a,  ram_data_b;
  logic [DW-1:0] ram_q_a,     ram_q_b;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    input  ram_ready_a, ram_ready_b, ram_q_a, ram_q_b,
    output req_ready, rsp_valid, rsp_data,
    output ram_valid_a, ram_valid_b, ram_we_a, ram_we_b,
    output ram_addr_a, ram_addr_b, ram_data_a, ram_data_b
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    output ram_ready_a, ram_ready_b, ram_q_a, ram_q_b,
    input  req_ready, rsp_valid, rsp_data,
    input  ram_valid_a, ram_valid_b, ram_we_a, ram_we_b,
    input  ram_addr_a, ram_addr_b, ram_data_a, ram_data_b
  );
endinterface

// File: rtl/dpram_arbiter.sv
// Round-robin arbiter sharing both ports of a dual-port RAM among NUM_REQ requesters,
// with same-address hazard blocking and one-cycle response routing.
module dpram_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned AW      = 6,
  parameter int unsigned DW      = 8
) (
  input  logic              clk,
  input  logic              rst_n,  // active-high asynchronous reset
  dpram_arbiter_if.slave    io_bus
);
  localparam int unsigned PW = $clog2(NUM_REQ);
  typedef logic [PW-1:0] idx_t;

  idx_t r_rr_ptr, w_rr_ptr_d;
  logic r_tag_a_vld, r_tag_b_vld;
  idx_t r_tag_a_idx, r_tag_b_idx;

  logic    w_w1_found, w_w2_found;
  idx_t    w_w1, w_w2;
  logic    w_hazard, w_gnt_a, w_gnt_b;
  idx_t    w_idx_a, w_idx_b, w_last;
  logic [AW-1:0] w_addr  [NUM_REQ];
  logic [DW-1:0] w_wdata [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    logic w_hit_a, w_hit_b;
    assign w_addr[gi]  = io_bus.req_addr[gi*AW +: AW];
    assign w_wdata[gi] = io_bus.req_wdata[gi*DW +: DW];
    assign io_bus.req_ready[gi] = (w_gnt_a && (w_idx_a == idx_t'(gi))) ||
                                  (w_gnt_b && (w_idx_b == idx_t'(gi)));
    assign w_hit_a = r_tag_a_vld && (r_tag_a_idx == idx_t'(gi));
    assign w_hit_b = r_tag_b_vld && (r_tag_b_idx == idx_t'(gi));
    assign io_bus.rsp_valid[gi] = w_hit_a || w_hit_b;
    assign io_bus.rsp_data[gi*DW +: DW] = w_hit_a ? io_bus.ram_q_a :
                                          w_hit_b ? io_bus.ram_q_b : '0;
  end

  // First two valid requesters found scanning upward from the pointer, with wrap.
  always_comb begin : scan
    logic [PW:0] v_sum;
    idx_t        v_idx;
    w_w1_found = 1'b0;
    w_w2_found = 1'b0;
    w_w1       = '0;
    w_w2       = '0;
    v_sum      = '0;
    v_idx      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      v_sum = {1'b0, r_rr_ptr} + (PW+1)'(k);
      if (v_sum >= (PW+1)'(NUM_REQ)) v_sum = v_sum - (PW+1)'(NUM_REQ);
      v_idx = v_sum[PW-1:0];
      if (io_bus.req_valid[v_idx]) begin
        if (!w_w1_found) begin
          w_w1_found = 1'b1;
          w_w1       = v_idx;
        end else if (!w_w2_found) begin
          w_w2_found = 1'b1;
          w_w2       = v_idx;
        end
      end
    end
  end

  assign w_hazard = (w_addr[w_w1] == w_addr[w_w2]) &&
                    (io_bus.req_we[w_w1] || io_bus.req_we[w_w2]);

  always_comb begin : grant
    w_gnt_a = 1'b0;
    w_gnt_b = 1'b0;
    w_idx_a = '0;
    w_idx_b = '0;
    if (!rst_n && w_w1_found) begin
      if (io_bus.ram_ready_a) begin
        w_gnt_a = 1'b1;
        w_idx_a = w_w1;
        if (io_bus.ram_ready_b && w_w2_found && !w_hazard) begin
          w_gnt_b = 1'b1;
          w_idx_b = w_w2;
        end
      end else if (io_bus.ram_ready_b) begin
        w_gnt_b = 1'b1;
        w_idx_b = w_w1;
      end
    end
  end

  always_comb begin : ram_drive
    io_bus.ram_valid_a = w_gnt_a;
    io_bus.ram_we_a    = w_gnt_a && io_bus.req_we[w_idx_a];
    io_bus.ram_addr_a  = w_gnt_a ? w_addr[w_idx_a]  : '0;
    io_bus.ram_data_a  = w_gnt_a ? w_wdata[w_idx_a] : '0;
    io_bus.ram_valid_b = w_gnt_b;
    io_bus.ram_we_b    = w_gnt_b && io_bus.req_we[w_idx_b];
    io_bus.ram_addr_b  = w_gnt_b ? w_addr[w_idx_b]  : '0;
    io_bus.ram_data_b  = w_gnt_b ? w_wdata[w_idx_b] : '0;
  end

  // Port B, when granted, always holds the later winner in scan order.
  always_comb begin : ptr_next
    w_last     = w_gnt_b ? w_idx_b : w_idx_a;
    w_rr_ptr_d = r_rr_ptr;
    if (w_gnt_a || w_gnt_b) begin
      w_rr_ptr_d = (w_last == idx_t'(NUM_REQ - 1)) ? '0 : w_last + idx_t'(1);
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_rr_ptr    <= '0;
      r_tag_a_vld <= 1'b0;
      r_tag_b_vld <= 1'b0;
      r_tag_a_idx <= '0;
      r_tag_b_idx <= '0;
    end else begin
      r_rr_ptr    <= w_rr_ptr_d;
      r_tag_a_vld <= w_gnt_a;
      r_tag_b_vld <= w_gnt_b;
      r_tag_a_idx <= w_idx_a;
      r_tag_b_idx <= w_idx_b;
    end
  end
endmodule

// File: tb/tb_dpram_arbiter.sv
// Directed self-checking bench for dpram_arbiter with a behavioural 64x8 dual-port RAM.
module tb_dpram_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [7:0] mem [64];

  always #5 clk = ~clk;

  dpram_arbiter_if bus_if ();

  dpram_arbiter u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus_if)
  );

  // RAM reads return pre-edge contents; writes echo the written data.
  always @(posedge clk) begin
    if (bus_if.ram_valid_a && bus_if.ram_ready_a) begin
      if (bus_if.ram_we_a) begin
        mem[bus_if.ram_addr_a] <= bus_if.ram_data_a;
        bus_if.ram_q_a         <= bus_if.ram_data_a;
      end else begin
        bus_if.ram_q_a <= mem[bus_if.ram_addr_a];
      end
    end
    if (bus_if.ram_valid_b && bus_if.ram_ready_b) begin
      if (bus_if.ram_we_b) begin
        mem[bus_if.ram_addr_b] <= bus_if.ram_data_b;
        bus_if.ram_q_b         <= bus_if.ram_data_b;
      end else begin
        bus_if.ram_q_b <= mem[bus_if.ram_addr_b];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic we, input logic [5:0] addr,
                         input logic [7:0] d);
    bus_if.req_valid[i]       = 1'b1;
    bus_if.req_we[i]          = we;
    bus_if.req_addr[i*6 +: 6] = addr;
    bus_if.req_wdata[i*8 +: 8] = d;
  endtask

  function automatic logic [7:0] rd(input int i);
    return bus_if.rsp_data[i*8 +: 8];
  endfunction

  task automatic do_reset();
    rst_n            = 1'b1;
    bus_if.req_valid = '0;
    @(negedge clk);
    rst_n = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 64; k++) mem[k] = 8'h40 + 8'(k);
    rst_n              = 1'b1;
    bus_if.ram_ready_a = 1'b1;
    bus_if.ram_ready_b = 1'b1;
    bus_if.req_valid   = '0;
    bus_if.req_we      = '0;
    bus_if.req_addr    = '0;
    bus_if.req_wdata   = '0;
    bus_if.ram_q_a     = '0;
    bus_if.ram_q_b     = '0;
    repeat (2) @(negedge clk);

    // Reset: nothing granted even with all requesters valid.
    bus_if.req_valid = 4'hF;
    #1;
    check_eq("rst_req_ready", 32'(bus_if.req_ready), 0);
    check_eq("rst_valid_a", 32'(bus_if.ram_valid_a), 0);
    check_eq("rst_valid_b", 32'(bus_if.ram_valid_b), 0);
    check_eq("rst_rsp_valid", 32'(bus_if.rsp_valid), 0);
    check_eq("rst_rsp_data", bus_if.rsp_data, 0);
    bus_if.req_valid = '0;
    @(negedge clk);
    rst_n = 1'b0;

    // Write 0xA5 to addr 5, then read it back from another requester.
    set_req(0, 1'b1, 6'd5, 8'hA5);
    #1;
    check_eq("t1_ready_w", 32'(bus_if.req_ready), 4'b0001);
    check_eq("t1_valid_a", 32'(bus_if.ram_valid_a), 1);
    check_eq("t1_we_a", 32'(bus_if.ram_we_a), 1);
    check_eq("t1_addr_a", 32'(bus_if.ram_addr_a), 5);
    check_eq("t1_data_a", 32'(bus_if.ram_data_a), 8'hA5);
    check_eq("t1_valid_b", 32'(bus_if.ram_valid_b), 0);
    @(negedge clk);
    check_eq("t1_rsp_v0", 32'(bus_if.rsp_valid), 4'b0001);
    check_eq("t1_rsp_d0", 32'(rd(0)), 8'hA5);
    bus_if.req_valid[0] = 1'b0;
    set_req(1, 1'b0, 6'd5, 8'h00);
    #1;
    check_eq("t1_ready_r", 32'(bus_if.req_ready), 4'b0010);
    check_eq("t1_we_a_rd", 32'(bus_if.ram_we_a), 0);
    @(negedge clk);
    check_eq("t1_rsp_v1", 32'(bus_if.rsp_valid), 4'b0010);
    check_eq("t1_rsp_d1", 32'(rd(1)), 8'hA5);
    bus_if.req_valid[1] = 1'b0;

    // All four read continuously: pairs alternate {0,1} / {2,3}.
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 6'(10 + i), 8'h00);
    #1;
    check_eq("t2_ready_01", 32'(bus_if.req_ready), 4'b0011);
    check_eq("t2_addr_a", 32'(bus_if.ram_addr_a), 10);
    check_eq("t2_addr_b", 32'(bus_if.ram_addr_b), 11);
    @(negedge clk);
    check_eq("t2_rsp_v01", 32'(bus_if.rsp_valid), 4'b0011);
    check_eq("t2_rsp_d0", 32'(rd(0)), 8'h4A);
    check_eq("t2_rsp_d1", 32'(rd(1)), 8'h4B);
    #1;
    check_eq("t2_ready_23", 32'(bus_if.req_ready), 4'b1100);
    check_eq("t2_addr_a2", 32'(bus_if.ram_addr_a), 12);
    @(negedge clk);
    check_eq("t2_rsp_v23", 32'(bus_if.rsp_valid), 4'b1100);
    check_eq("t2_rsp_d2", 32'(rd(2)), 8'h4C);
    check_eq("t2_rsp_d3", 32'(rd(3)), 8'h4D);
    #1;
    check_eq("t2_ready_01b", 32'(bus_if.req_ready), 4'b0011);
    @(negedge clk);
    check_eq("t2_rsp_v01b", 32'(bus_if.rsp_valid), 4'b0011);
    check_eq("t2_rsp_d0b", 32'(rd(0)), 8'h4A);
    bus_if.req_valid = '0;

    // Two writes to the same address: only the first is granted.
    do_reset();
    set_req(0, 1'b1, 6'd9, 8'h11);
    set_req(1, 1'b1, 6'd9, 8'h22);
    #1;
    check_eq("t3_ready_haz", 32'(bus_if.req_ready), 4'b0001);
    check_eq("t3_valid_b", 32'(bus_if.ram_valid_b), 0);
    check_eq("t3_data_a", 32'(bus_if.ram_data_a), 8'h11);
    @(negedge clk);
    check_eq("t3_rsp_v0", 32'(bus_if.rsp_valid), 4'b0001);
    check_eq("t3_rsp_d0", 32'(rd(0)), 8'h11);
    bus_if.req_valid[0] = 1'b0;
    #1;
    check_eq("t3_ready_1", 32'(bus_if.req_ready), 4'b0010);
    check_eq("t3_data_a1", 32'(bus_if.ram_data_a), 8'h22);
    @(negedge clk);
    check_eq("t3_rsp_v1", 32'(bus_if.rsp_valid), 4'b0010);
    bus_if.req_valid[1] = 1'b0;
    set_req(2, 1'b0, 6'd9, 8'h00);
    #1;
    check_eq("t3_ready_2", 32'(bus_if.req_ready), 4'b0100);
    @(negedge clk);
    check_eq("t3_rsp_v2", 32'(bus_if.rsp_valid), 4'b0100);
    check_eq("t3_rsp_d2", 32'(rd(2)), 8'h22);
    bus_if.req_valid[2] = 1'b0;

    // No ports ready, then only port B ready.
    do_reset();
    bus_if.ram_ready_a = 1'b0;
    bus_if.ram_ready_b = 1'b0;
    set_req(2, 1'b0, 6'd20, 8'h00);
    set_req(3, 1'b0, 6'd21, 8'h00);
    #1;
    check_eq("t4_ready_none", 32'(bus_if.req_ready), 0);
    check_eq("t4_valid_a0", 32'(bus_if.ram_valid_a), 0);
    check_eq("t4_valid_b0", 32'(bus_if.ram_valid_b), 0);
    @(negedge clk);
    check_eq("t4_rsp_none", 32'(bus_if.rsp_valid), 0);
    bus_if.ram_ready_b = 1'b1;
    #1;
    check_eq("t4_ready_2", 32'(bus_if.req_ready), 4'b0100);
    check_eq("t4_valid_a1", 32'(bus_if.ram_valid_a), 0);
    check_eq("t4_valid_b1", 32'(bus_if.ram_valid_b), 1);
    check_eq("t4_addr_b", 32'(bus_if.ram_addr_b), 20);
    @(negedge clk);
    check_eq("t4_rsp_v2", 32'(bus_if.rsp_valid), 4'b0100);
    check_eq("t4_rsp_d2", 32'(rd(2)), 8'h54);
    bus_if.req_valid[2] = 1'b0;
    #1;
    check_eq("t4_ready_3", 32'(bus_if.req_ready), 4'b1000);
    check_eq("t4_valid_a2", 32'(bus_if.ram_valid_a), 0);
    check_eq("t4_addr_b3", 32'(bus_if.ram_addr_b), 21);
    @(negedge clk);
    check_eq("t4_rsp_v3", 32'(bus_if.rsp_valid), 4'b1000);
    check_eq("t4_rsp_d3", 32'(rd(3)), 8'h55);
    bus_if.req_valid[3] = 1'b0;
    bus_if.ram_ready_a  = 1'b1;

    // Reset while a response is in flight discards it and clears the pointer.
    do_reset();
    set_req(1, 1'b0, 6'd10, 8'h00);
    #1;
    check_eq("t5_ready_1", 32'(bus_if.req_ready), 4'b0010);
    @(negedge clk);
    bus_if.req_valid[1] = 1'b0;
    rst_n = 1'b1;
    #1;
    check_eq("t5_rsp_flush", 32'(bus_if.rsp_valid), 0);
    @(negedge clk);
    check_eq("t5_rsp_hold", 32'(bus_if.rsp_valid), 0);
    rst_n = 1'b0;
    set_req(0, 1'b0, 6'd30, 8'h00);
    set_req(3, 1'b0, 6'd31, 8'h00);
    #1;
    check_eq("t5_ready_03", 32'(bus_if.req_ready), 4'b1001);
    check_eq("t5_addr_a", 32'(bus_if.ram_addr_a), 30);
    check_eq("t5_addr_b", 32'(bus_if.ram_addr_b), 31);
    @(negedge clk);
    check_eq("t5_rsp_v03", 32'(bus_if.rsp_valid), 4'b1001);
    check_eq("t5_rsp_d0", 32'(rd(0)), 8'h5E);
    check_eq("t5_rsp_d3", 32'(rd(3)), 8'h5F);
    bus_if.req_valid = '0;

    // Two reads of the same address are both granted.
    do_reset();
    set_req(0, 1'b0, 6'd7, 8'h00);
    set_req(1, 1'b0, 6'd7, 8'h00);
    #1;
    check_eq("t6_ready_01", 32'(bus_if.req_ready), 4'b0011);
    check_eq("t6_valid_b", 32'(bus_if.ram_valid_b), 1);
    check_eq("t6_addr_b", 32'(bus_if.ram_addr_b), 7);
    @(negedge clk);
    check_eq("t6_rsp_v01", 32'(bus_if.rsp_valid), 4'b0011);
    check_eq("t6_rsp_d0", 32'(rd(0)), 8'h47);
    check_eq("t6_rsp_d1", 32'(rd(1)), 8'h47);
    bus_if.req_valid = '0;

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dpram_arbiter.md
Name: dpram_arbiter

Overview:
- Round-robin arbiter that shares the two ports (A, B) of the 64x8 dual-port RAM among NUM_REQ requesters.
- Each cycle it grants up to two requests, first winner to port A and second to port B.
- It drives the RAM valid/ready handshake, blocks same-address hazards between the two ports, and routes each RAM result back to the requester that issued it.
- It sits between the client masters and the RAM instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- AW, 6, address width (matches 64-entry RAM)
- DW, 8, data width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-high (asserted = 1) despite the name
- req_valid  in  NUM_REQ  request valid, one bit per requester
- req_ready  out  NUM_REQ  request accepted this cycle (combinational)
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*AW  flattened addresses; requester i at [i*AW +: AW]
- req_wdata  in  NUM_REQ*DW  flattened write data
- rsp_valid  out  NUM_REQ  response valid (registered)
- rsp_data  out  NUM_REQ*DW  read data, or echoed write data
- ram_valid_a, ram_valid_b  out  1  RAM port request valid
- ram_ready_a, ram_ready_b  in  1  RAM port ready
- ram_we_a, ram_we_b  out  1  RAM write enable
- ram_addr_a, ram_addr_b  out  AW  RAM address
- ram_data_a, ram_data_b  out  DW  RAM write data
- ram_q_a, ram_q_b  in  DW  RAM output; updated at the edge that completes the handshake

Behaviour:

Reset (rst_n = 1, async):
- rr_ptr = 0; tag_a/tag_b cleared (valid = 0).
- rsp_valid = 0, rsp_data = 0.
- ram_valid_* = 0 while reset is asserted; req_ready = 0.
- Any response in flight at reset is discarded; no rsp_valid follows reset release.

Arbitration (combinational, each cycle):
- Scan requesters starting at rr_ptr, wrapping modulo NUM_REQ.
- First valid requester = W1; next valid requester after W1 = W2.
- Available ports are those with ram_ready_x = 1. W1 takes the lowest available port (A before B); W2 takes the remaining port, if any.
- Hazard: if W1 and W2 have equal addresses and either is a write, W2 is not granted this cycle; W1 still proceeds. Two reads to the same address are both granted.
- Granted port: ram_valid_x = 1; ram_we/addr/data = the winner's fields. Ungranted port: ram_valid_x = 0; other RAM outputs are don't-care but held at 0.
- req_ready[i] = 1 only for granted requesters; transfer occurs when req_valid & req_ready.
- Requesters hold valid and payload until accepted. No starvation: any waiting requester is granted within NUM_REQ cycles while at least one RAM port is ready.

Pointer:
- On any grant, rr_ptr <= (index of last granted requester + 1) mod NUM_REQ.
- No grant: rr_ptr holds.

Response path (latency 1):
- At the grant edge, tag_x <= {1, requester index}; otherwise tag_x valid <= 0.
- In the following cycle, requester tag_x.idx gets rsp_valid = 1, rsp_data = ram_q_x (read data, or the written data for writes).
- rsp_valid is a one-cycle pulse; there is no backpressure on responses.
- Back-to-back grants to the same requester yield back-to-back responses in issue order.
- A requester can hold at most one grant per cycle, so two same-cycle responses always target different requesters.

Simultaneous and boundary cases:
- Both ram_ready low: no grants; requests wait.
- Only ram_ready_b high: W1 goes to port B; W2 waits.
- A single requester is never granted both ports in one cycle.
- Address wrap 63 -> 0 is pure RAM behaviour; the arbiter does no address arithmetic.

Test Plan:
- Reset, then requester 0 writes 0xA5 to addr 5; next cycle requester 1 reads addr 5 -> requester 0 gets rsp_valid with 0xA5 one cycle after grant; requester 1 gets rsp_data = 0xA5 one cycle after its grant.
- All 4 requesters read distinct addresses continuously, rr_ptr = 0 -> grants {0→A, 1→B}, then {2→A, 3→B}, then {0, 1}; each requester gets one response every 2 cycles.
- Requester 0 writes 0x11 and requester 1 writes 0x22, both to addr 9, same cycle -> only requester 0 is granted; requester 1 is granted the next cycle; a final read of addr 9 returns 0x22.
- ram_ready_a = 0, ram_ready_b = 1, requesters 2 and 3 valid -> requester 2 uses port B, requester 3 waits one cycle, ram_valid_a = 0 throughout.
- Requester 1 read granted, rst_n pulsed high the next cycle -> rsp_valid stays 0 and rr_ptr = 0 after release.
- Two reads from requesters 0 and 1 to addr 7 in the same cycle -> both granted (A and B); both get identical rsp_data.
